// File: rtl/store_port_arbiter.sv
// Round-robin arbiter funnelling several store requesters onto one D$ write port.
// A single transaction is in flight at a time; flush drops or silences it.
module store_port_arbiter #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 56
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NR_PORTS-1:0]          req_i,
    input  logic [NR_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [NR_PORTS*DATA_W-1:0]   wdata_i,
    input  logic [NR_PORTS*DATA_W/8-1:0] be_i,
    input  logic [NR_PORTS*2-1:0]        size_i,
    output logic [NR_PORTS-1:0]          gnt_o,
    output logic [NR_PORTS-1:0]          rsp_valid_o,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic [DATA_W/8-1:0]          mem_be_o,
    output logic [1:0]                   mem_size_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               drop_q, drop_d;
    logic               mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic [BE_W-1:0]    mem_be_d;
    logic [1:0]         mem_size_d;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic [1:0]         sel_size;
    logic               capture;
    logic               gnt_fire;
    logic               rsp_fire;

    // Round-robin pick: scan priority offsets 1..NR_PORTS starting after last_q.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (!arb_valid && req_i[p] &&
                    (p == (32'(last_q) + 32'd1 + i) % NR_PORTS)) begin
                    arb_valid = 1'b1;
                    arb_idx   = IDX_W'(p);
                end
            end
        end
    end

    // Payload mux for the current arbitration winner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_size  = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (arb_idx == IDX_W'(p)) begin
                sel_addr  = addr_i[p*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[p*DATA_W +: DATA_W];
                sel_be    = be_i[p*BE_W +: BE_W];
                sel_size  = size_i[p*2 +: 2];
            end
        end
    end

    // Next-state logic; leaving RESP re-arbitrates in the same cycle.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        mem_be_d    = mem_be_o;
        mem_size_d  = mem_size_o;
        capture     = 1'b0;
        gnt_fire    = 1'b0;
        rsp_fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid && !flush_i) begin
                    capture = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    gnt_fire  = 1'b1;
                    last_d    = win_q;
                    mem_req_d = 1'b0;
                    drop_d    = flush_i;
                    state_d   = RESP;
                end else if (flush_i) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RESP: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    rsp_fire = !drop_q;
                    drop_d   = 1'b0;
                    state_d  = IDLE;
                    if (arb_valid && !flush_i) begin
                        capture = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            state_d     = REQ;
            win_d       = arb_idx;
            mem_req_d   = 1'b1;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_be_d    = sel_be;
            mem_size_d  = sel_size;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NR_PORTS - 1);
            win_q       <= '0;
            drop_q      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            mem_size_o  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            drop_q      <= drop_d;
            mem_req_o   <= mem_req_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            mem_be_o    <= mem_be_d;
            mem_size_o  <= mem_size_d;
        end
    end

    // Same-cycle handshake pulses decoded from the held winner index.
    always_comb begin
        gnt_o       = '0;
        rsp_valid_o = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            gnt_o[p]       = gnt_fire && (win_q == IDX_W'(p));
            rsp_valid_o[p] = rsp_fire && (win_q == IDX_W'(p));
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed bench for store_port_arbiter: single request, contention, stall,
// flush variants and asynchronous reset mid-transaction.
module tb_store_port_arbiter;

    localparam int unsigned NR_PORTS = 2;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 56;
    localparam int unsigned BE_W     = DATA_W / 8;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic                         flush_i;
    logic [NR_PORTS-1:0]          req_i;
    logic [NR_PORTS*ADDR_W-1:0]   addr_i;
    logic [NR_PORTS*DATA_W-1:0]   wdata_i;
    logic [NR_PORTS*BE_W-1:0]     be_i;
    logic [NR_PORTS*2-1:0]        size_i;
    logic [NR_PORTS-1:0]          gnt_o;
    logic [NR_PORTS-1:0]          rsp_valid_o;
    logic                         mem_req_o;
    logic [ADDR_W-1:0]            mem_addr_o;
    logic [DATA_W-1:0]            mem_wdata_o;
    logic [BE_W-1:0]              mem_be_o;
    logic [1:0]                   mem_size_o;
    logic                         mem_gnt_i;
    logic                         mem_rvalid_i;
    logic                         busy_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    store_port_arbiter #(
        .NR_PORTS(NR_PORTS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .size_i      (size_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_size_o  (mem_size_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked mid-cycle.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic fl);
        req_i        = req;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        flush_i      = fl;
    endtask

    initial begin
        logic [1:0]  oh;
        int unsigned exp_port;

        rst_i   = 1'b1;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        size_i  = '0;
        drive(2'b01, 1'b1, 1'b1, 1'b0);
        #2;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rsp", 64'(rsp_valid_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        // Single request on port 0
        addr_i  = {56'h0, 56'h80};
        wdata_i = {64'h0, 64'hDEAD_BEEF_0123_4567};
        be_i    = {8'h00, 8'h0F};
        size_i  = {2'b00, 2'b10};
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_idle_memreq", 64'(mem_req_o), 64'd0);
        chk("t1_idle_gnt", 64'(gnt_o), 64'd0);
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t1_memreq", 64'(mem_req_o), 64'd1);
        chk("t1_addr", 64'(mem_addr_o), 64'h80);
        chk("t1_wdata", mem_wdata_o, 64'hDEAD_BEEF_0123_4567);
        chk("t1_be", 64'(mem_be_o), 64'h0F);
        chk("t1_size", 64'(mem_size_o), 64'd2);
        chk("t1_gnt", 64'(gnt_o), 64'b01);
        chk("t1_busy", 64'(busy_o), 64'd1);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t1_rsp", 64'(rsp_valid_o), 64'b01);
        chk("t1_memreq_low", 64'(mem_req_o), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_idle_busy", 64'(busy_o), 64'd0);
        chk("t1_idle_rsp", 64'(rsp_valid_o), 64'd0);
        next_cycle();

        // Reset in IDLE restores port-0-first priority
        rst_i = 1'b1;
        settle();
        chk("rst2_busy", 64'(busy_o), 64'd0);
        next_cycle();
        rst_i = 1'b0;

        // Contention: both ports held, immediate grant and response
        addr_i = {56'h200, 56'h100};
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t2_idle_gnt", 64'(gnt_o), 64'd0);
        chk("t2_idle_rsp", 64'(rsp_valid_o), 64'd0);
        next_cycle();
        for (int k = 0; k < 7; k++) begin
            settle();
            exp_port = 32'(k / 2) % 2;
            oh = 2'(1 << exp_port);
            if (k % 2 == 0) begin
                chk($sformatf("t2_gnt_%0d", k), 64'(gnt_o), 64'(oh));
                chk($sformatf("t2_addr_%0d", k), 64'(mem_addr_o),
                    (exp_port == 1) ? 64'h200 : 64'h100);
                chk($sformatf("t2_norsp_%0d", k), 64'(rsp_valid_o), 64'd0);
            end else begin
                chk($sformatf("t2_rsp_%0d", k), 64'(rsp_valid_o), 64'(oh));
                chk($sformatf("t2_nognt_%0d", k), 64'(gnt_o), 64'd0);
            end
            next_cycle();
        end
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t2_last_rsp", 64'(rsp_valid_o), 64'b10);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_idle_busy", 64'(busy_o), 64'd0);
        next_cycle();

        // Stalled grant: payload held while requester drops and input changes
        addr_i = {56'h0, 56'h300};
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        next_cycle();
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin
                req_i  = 2'b00;
                addr_i = {56'h0, 56'h999};
            end
            settle();
            chk($sformatf("t3_memreq_%0d", s), 64'(mem_req_o), 64'd1);
            chk($sformatf("t3_addr_%0d", s), 64'(mem_addr_o), 64'h300);
            chk($sformatf("t3_nognt_%0d", s), 64'(gnt_o), 64'd0);
            next_cycle();
        end
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3_gnt", 64'(gnt_o), 64'b01);
        chk("t3_addr_gnt", 64'(mem_addr_o), 64'h300);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t3_rsp", 64'(rsp_valid_o), 64'b01);
        chk("t3_nognt", 64'(gnt_o), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);

        // Flush in REQ before grant; priority must not advance
        addr_i = {56'h440, 56'h400};
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        settle();
        next_cycle();
        drive(2'b10, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t4_flush_gnt", 64'(gnt_o), 64'd0);
        chk("t4_flush_memreq", 64'(mem_req_o), 64'd1);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t4_memreq_low", 64'(mem_req_o), 64'd0);
        chk("t4_busy_low", 64'(busy_o), 64'd0);
        next_cycle();
        drive(2'b11, 1'b0, 1'b0, 1'b0);
        settle();
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t4_gnt_port1", 64'(gnt_o), 64'b10);
        chk("t4_addr_port1", 64'(mem_addr_o), 64'h440);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t4_rsp", 64'(rsp_valid_o), 64'b10);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);

        // Flush coinciding with grant: grant wins, response suppressed
        addr_i = {56'h0, 56'h500};
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 1'b1);
        settle();
        chk("t5_gnt", 64'(gnt_o), 64'b01);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t5_memreq_low", 64'(mem_req_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd1);
        next_cycle();
        settle();
        chk("t5_wait_rsp", 64'(rsp_valid_o), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t5_dropped_rsp", 64'(rsp_valid_o), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t5_idle", 64'(busy_o), 64'd0);
        next_cycle();

        // Asynchronous reset while waiting in RESP
        addr_i = {56'h0, 56'h600};
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_gnt", 64'(gnt_o), 64'b01);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_resp_busy", 64'(busy_o), 64'd1);
        rst_i        = 1'b1;
        mem_rvalid_i = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_memreq", 64'(mem_req_o), 64'd0);
        chk("t6_rst_rsp", 64'(rsp_valid_o), 64'd0);
        next_cycle();
        rst_i = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t6_late_rsp", 64'(rsp_valid_o), 64'd0);
        chk("t6_late_busy", 64'(busy_o), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
